seven_segment_scanner: RTL and testbench
========================================

# seven_segment_scanner

- Parametrised successor to the 4-digit seven-segment driver: time-multiplexes `DIGITS` hex nibbles onto one common-anode display.
- Adds on-chip hex-to-segment decoding, per-digit decimal points, tear-free frame latching, a configurable on/blank duty cycle for ghost suppression, and a display enable.
- Sits between the counter/datapath producing `q` and the board display pins. It is paced by the slow scan strobe `clk_div` from the clock divider.

## Interface
Parameters:
- `DIGITS`, 4, number of digits (≥2); digit 0 is rightmost, `q[3:0]`.
- `ON_TICKS`, 1, scan ticks each digit is lit (≥1).
- `BLANK_TICKS`, 0, scan ticks with all anodes off between digits (0 = no blanking).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clk_div`  in  1  slow scan strobe; each 0→1 transition sampled on `clk` is one scan tick.
- `q`  in  4*DIGITS  hex value to display.
- `dp`  in  DIGITS  decimal point request per digit, active-high.
- `en`  in  1  display enable.
- `d`  out  4  nibble of the currently selected digit.
- `a`  out  DIGITS  anode selects, active-low.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp_n`  out  1  decimal point segment, active-low.
- `frame`  out  1  one-cycle pulse when a new frame is latched.

## Operation
- **Tick detection**
  - `clk_div_q` is a registered copy of `clk_div`.
  - tick = `clk_div & ~clk_div_q`.
  - `clk_div_q` resets to 1, so a `clk_div` held high through reset produces no tick until it has been sampled low.
- **Scan FSM**: states BLANK and SHOW, plus index `idx` (0..DIGITS-1), tick counter `cnt`, and shadow registers `q_s` and `dp_s`.
- **Reset**: state=BLANK, `idx`=DIGITS-1, `cnt`=0, `q_s`=0, `dp_s`=0.
- **Advance**:
  - `idx` ← `idx`+1, wrapping DIGITS-1→0.
  - When the new `idx` is 0: `q_s`←`q`, `dp_s`←`dp`, and `frame` pulses.
  - `cnt`←0.
- **BLANK, on tick**: if `cnt`+1 ≥ max(BLANK_TICKS,1), advance and go to SHOW; else `cnt`++.
- **SHOW, on tick**: if `cnt`+1 = ON_TICKS:
  - BLANK_TICKS=0: advance and stay in SHOW.
  - otherwise: go to BLANK with `cnt`=0.
  - If `cnt`+1 < ON_TICKS: `cnt`++.
- **Outputs in SHOW with `en`=1**:
  - `a` has only bit `idx` low.
  - `d` = `q_s[4*idx+:4]`.
  - `seg` = hex decode of `d`.
  - `dp_n` = ~`dp_s[idx]`.
- **Outputs in BLANK, or with `en`=0**:
  - `a`=all ones, `seg`=7'h7F, `dp_n`=1.
  - `d` still tracks `idx`.
  - Scanning, latching and `frame` continue regardless of `en`.
- **Decode table**:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- **Frame latching**: `q` and `dp` changes mid-frame never reach the display until the next wrap to digit 0.

## Timing
- Edge E is the first `clk` edge at which `clk_div`=1 after it was sampled 0. FSM, `idx`, `cnt` and the shadow registers update at E.
- `a`, `d`, `seg`, `dp_n` and `frame` are registered and update at E+1, so latency from strobe rise to pins is 2 `clk` edges.
- `frame` is high for exactly one `clk` cycle per frame.
- Reset values:
  - `a`=all ones, `seg`=7'h7F, `dp_n`=1, `d`=0, `frame`=0.
  - These hold from the first edge with `rst`=1 until E+1 of the first tick after release.
- `rst` asserted mid-frame: all state and outputs return to reset values at that edge. A pending tick is discarded.
- `en` change takes effect on outputs one `clk` edge later. It never alters `idx` or `cnt`.
- One digit period = (ON_TICKS + BLANK_TICKS) scan ticks.

## Configuration
- Macro: `SEVSEG_LZB_EN` (leading-zero blanking).
- **Defined**: in SHOW, digit `idx`>0 keeps all anodes off when:
  - its nibble and every more-significant `q_s` nibble are 0, and
  - its `dp_s` bit is 0.
  - Digit 0 is never blanked.
  - Timing and `frame` are unchanged.
- **Undefined**: every digit is always shown, including leading zeros.

## Test plan
1. `rst`=1 with `clk_div`=1, then release → outputs stay `a`=F, `seg`=7F, `dp_n`=1, `frame`=0 until `clk_div` falls and rises again. Reset asserted mid-frame returns the same values on the next edge.
2. DIGITS=4, ON=1, BLANK=0, `q`=16'h1234, `dp`=0 → per tick (`a`,`d`,`seg`) = (E,4,19), (D,3,30), (B,2,24), (7,1,79), then repeats. `frame` is a 1-cycle pulse with each `a`=E, at edge E+1.
3. Change `q` from 1234 to ABCD while `idx`=2 → digits 2 and 1 still show 2 and 1. The next frame shows D,C,b,A (`seg` 21,46,03,08).
4. ON_TICKS=3, BLANK_TICKS=2 → each digit lit for exactly 3 ticks, then `a`=F and `seg`=7F for 2 ticks; digit sequence 0,1,2,3 continues.
5. `en`=0 for one full frame → `a`=F throughout while `frame` still pulses. On `en`=1 the display resumes at the current `idx` one edge later. `dp`=4'b0100 gives `dp_n`=0 only while `a`=B.
6. `q`=16'h0070, `dp`=0:
   - with `SEVSEG_LZB_EN`: digits 3 and 2 dark; digit 1 `seg`=78, digit 0 `seg`=40.
   - without it: digits 3 and 2 show `seg`=40.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// seven_segment_scanner
//
// Time-multiplexes DIGITS hex nibbles onto one common-anode seven-segment
// display. Each rising edge of the slow strobe clk_div (sampled on clk) is one
// scan tick. A digit is lit for ON_TICKS ticks, optionally followed by
// BLANK_TICKS ticks with every anode off to suppress ghosting. The displayed
// value and decimal points are copied into shadow registers only when the scan
// wraps back to digit 0, so a frame never mixes old and new data.
//
// Parameters:
//   DIGITS      number of digits (>= 2); digit 0 is rightmost, q[3:0]
//   ON_TICKS    scan ticks each digit is lit (>= 1)
//   BLANK_TICKS scan ticks with all anodes off between digits (0 = none)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   clk_div  in   slow scan strobe; every 0->1 transition is one scan tick
//   q        in   [4*DIGITS] hex value to display
//   dp       in   [DIGITS] decimal point request per digit, active-high
//   en       in   display enable (scanning continues while disabled)
//   d        out  [4] nibble of the currently selected digit
//   a        out  [DIGITS] anode selects, active-low
//   seg      out  [7] segments {g,f,e,d,c,b,a}, active-low
//   dp_n     out  decimal point segment, active-low
//   frame    out  one-cycle pulse when a new frame has been latched
//
// Build option:
//   SEVSEG_LZB_EN  when defined, leading zero digits (idx > 0, nibble and all
//                  more-significant nibbles zero, decimal point off) stay dark.
// -----------------------------------------------------------------------------
module seven_segment_scanner #(
   parameter int DIGITS      = 4,
   parameter int ON_TICKS    = 1,
   parameter int BLANK_TICKS = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clk_div,
   input  logic [4*DIGITS-1:0]   q,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  en,
   output logic [3:0]            d,
   output logic [DIGITS-1:0]     a,
   output logic [6:0]            seg,
   output logic                  dp_n,
   output logic                  frame
);

   localparam int IDX_W     = $clog2(DIGITS);
   localparam int BLANK_MIN = (BLANK_TICKS > 1) ? BLANK_TICKS : 1;
   localparam int CNT_MAX   = (ON_TICKS > BLANK_MIN) ? ON_TICKS : BLANK_MIN;
   localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
   localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_TICKS - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_MIN - 1);

   typedef enum logic {BLANK, SHOW} state_t;

   // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   logic                  clk_div_q;
   state_t                state;
   logic [IDX_W-1:0]      idx;
   logic [CNT_W-1:0]      cnt;
   logic [4*DIGITS-1:0]   q_s;
   logic [DIGITS-1:0]     dp_s;
   logic                  frame_p0;

   logic                  tick_p0;
   logic                  adv;
   logic [IDX_W-1:0]      idx_nxt;
   logic                  wrap;
   logic [3:0]            nib;
   logic                  lzb;
   logic                  lit;

   // ---- stage p0: tick detection and scan decisions ----
   assign tick_p0 = clk_div & ~clk_div_q;
   assign wrap    = (idx == IDX_LAST);
   assign idx_nxt = wrap ? '0 : idx + IDX_W'(1);
   // Moving to the next digit happens at the end of a blank gap, or at the end
   // of the lit period when there is no blank gap at all.
   assign adv     = tick_p0 &&
                    (((state == BLANK) && (cnt == BLANK_LAST)) ||
                     ((state == SHOW) && (cnt == ON_LAST) && (BLANK_TICKS == 0)));
   assign nib     = q_s[{idx, 2'b00} +: 4];

`ifdef SEVSEG_LZB_EN
   // Bit i is set when nibble i and every more-significant nibble are zero.
   function automatic logic [DIGITS-1:0] zero_above(input logic [4*DIGITS-1:0] v);
      logic [DIGITS-1:0] z;
      z[DIGITS-1] = (v[4*DIGITS-1 -: 4] == 4'd0);
      for (int i = DIGITS - 2; i >= 0; i--) begin
         z[i] = (v[4*i +: 4] == 4'd0) && z[i+1];
      end
      return z;
   endfunction

   logic [DIGITS-1:0] zero_from;
   assign zero_from = zero_above(q_s);
   assign lzb       = (idx != '0) && zero_from[idx] && !dp_s[idx];
`else
   assign lzb = 1'b0;
`endif

   assign lit = (state == SHOW) && en && !lzb;

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_div_q <= 1'b1;
         state     <= BLANK;
         idx       <= IDX_LAST;
         cnt       <= '0;
         q_s       <= '0;
         dp_s      <= '0;
         frame_p0  <= 1'b0;
         a         <= '1;
         seg       <= 7'h7F;
         dp_n      <= 1'b1;
         d         <= 4'd0;
         frame     <= 1'b0;
      end else begin
         clk_div_q <= clk_div;
         frame_p0  <= 1'b0;
         if (adv) begin
            state <= SHOW;
            idx   <= idx_nxt;
            cnt   <= '0;
            if (wrap) begin
               q_s      <= q;
               dp_s     <= dp;
               frame_p0 <= 1'b1;
            end
         end else if (tick_p0) begin
            if ((state == SHOW) && (cnt == ON_LAST)) begin
               state <= BLANK;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end

         // ---- stage p1: registered pin drivers from the updated scan state ----
         d     <= nib;
         frame <= frame_p0;
         if (lit) begin
            a    <= ~(DIGITS'(1) << idx);
            seg  <= hex7(nib);
            dp_n <= ~dp_s[idx];
         end else begin
            a    <= '1;
            seg  <= 7'h7F;
            dp_n <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scanner
//
// Two scanner instances: u0 (4 digits, ON=1, BLANK=0) and u1 (4 digits, ON=3,
// BLANK=2), each with its own scan strobe. Stimulus pushes the hand-derived
// pin state expected after each strobe into a per-instance queue; a monitor per
// instance detects strobe rises on its own and compares two edges later.
// -----------------------------------------------------------------------------
module tb_seven_segment_scanner;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] d;
      logic [6:0] seg;
      logic       dp_n;
      logic       frame;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        clk_div0;
   logic        clk_div1;
   logic [15:0] q;
   logic [3:0]  dp;
   logic        en;

   logic [3:0]  d0, a0, d1, a1;
   logic [6:0]  seg0, seg1;
   logic        dpn0, dpn1, frame0, frame1;

   exp_t sb0[$];
   exp_t sb1[$];

   int n_chk  = 0;
   int n_pass = 0;

   seven_segment_scanner #(.DIGITS(4), .ON_TICKS(1), .BLANK_TICKS(0)) u0 (
      .clk(clk), .rst(rst), .clk_div(clk_div0), .q(q), .dp(dp), .en(en),
      .d(d0), .a(a0), .seg(seg0), .dp_n(dpn0), .frame(frame0)
   );

   seven_segment_scanner #(.DIGITS(4), .ON_TICKS(3), .BLANK_TICKS(2)) u1 (
      .clk(clk), .rst(rst), .clk_div(clk_div1), .q(q), .dp(dp), .en(en),
      .d(d1), .a(a1), .seg(seg1), .dp_n(dpn1), .frame(frame1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(input logic [3:0] ea, input logic [3:0] ed,
                               input logic [6:0] es, input logic edp,
                               input logic efr);
      exp_t e;
      e.a = ea; e.d = ed; e.seg = es; e.dp_n = edp; e.frame = efr;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   task automatic chk_pins(input string tag, input exp_t act, input exp_t req);
      chk({tag, "_a"},     32'(act.a),     32'(req.a));
      chk({tag, "_d"},     32'(act.d),     32'(req.d));
      chk({tag, "_seg"},   32'(act.seg),   32'(req.seg));
      chk({tag, "_dp_n"},  32'(act.dp_n),  32'(req.dp_n));
      chk({tag, "_frame"}, 32'(act.frame), 32'(req.frame));
   endtask

   function automatic exp_t pins0();
      return mk(a0, d0, seg0, dpn0, frame0);
   endfunction

   function automatic exp_t pins1();
      return mk(a1, d1, seg1, dpn1, frame1);
   endfunction

   task automatic do_tick(input int which, input exp_t e);
      if (which == 0) begin
         sb0.push_back(e);
         @(negedge clk) clk_div0 = 1'b1;
         @(negedge clk) clk_div0 = 1'b0;
      end else begin
         sb1.push_back(e);
         @(negedge clk) clk_div1 = 1'b1;
         @(negedge clk) clk_div1 = 1'b0;
      end
      repeat (2) @(negedge clk);
   endtask

   // ---- monitor for u0 ----
   initial begin : mon0
      logic prev, pend, fchk;
      int   k;
      exp_t e;
      prev = 1'b1; pend = 1'b0; fchk = 1'b0; k = 0;
      forever begin
         @(posedge clk); #1;
         if (fchk) begin
            chk($sformatf("u0_t%0d_frame_width", k), 32'(frame0), 32'd0);
            fchk = 1'b0;
         end
         if (rst) begin
            prev = 1'b1; pend = 1'b0;
         end else begin
            if (pend) begin
               k++;
               if (sb0.size() == 0) begin
                  chk($sformatf("u0_t%0d_unexpected_output", k), 32'd1, 32'd0);
               end else begin
                  e = sb0.pop_front();
                  chk_pins($sformatf("u0_t%0d", k), pins0(), e);
                  fchk = e.frame;
               end
            end
            pend = clk_div0 & ~prev;
            prev = clk_div0;
         end
      end
   end

   // ---- monitor for u1 ----
   initial begin : mon1
      logic prev, pend, fchk;
      int   k;
      exp_t e;
      prev = 1'b1; pend = 1'b0; fchk = 1'b0; k = 0;
      forever begin
         @(posedge clk); #1;
         if (fchk) begin
            chk($sformatf("u1_t%0d_frame_width", k), 32'(frame1), 32'd0);
            fchk = 1'b0;
         end
         if (rst) begin
            prev = 1'b1; pend = 1'b0;
         end else begin
            if (pend) begin
               k++;
               if (sb1.size() == 0) begin
                  chk($sformatf("u1_t%0d_unexpected_output", k), 32'd1, 32'd0);
               end else begin
                  e = sb1.pop_front();
                  chk_pins($sformatf("u1_t%0d", k), pins1(), e);
                  fchk = e.frame;
               end
            end
            pend = clk_div1 & ~prev;
            prev = clk_div1;
         end
      end
   end

   // ---- stimulus ----
   initial begin
      rst = 1'b1; clk_div0 = 1'b1; clk_div1 = 1'b1;
      q = 16'h1234; dp = 4'b0000; en = 1'b1;

      // Reset with the strobe held high, then release: no tick until it falls.
      repeat (3) @(negedge clk);
      chk_pins("rst_u0", pins0(), mk(4'hF, 4'h0, 7'h7F, 1'b1, 1'b0));
      chk_pins("rst_u1", pins1(), mk(4'hF, 4'h0, 7'h7F, 1'b1, 1'b0));
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk_pins("rel_u0", pins0(), mk(4'hF, 4'h0, 7'h7F, 1'b1, 1'b0));
      chk_pins("rel_u1", pins1(), mk(4'hF, 4'h0, 7'h7F, 1'b1, 1'b0));
      clk_div0 = 1'b0; clk_div1 = 1'b0;
      @(negedge clk);

      // Basic scan of 1234.
      do_tick(0, mk(4'hE, 4'h4, 7'h19, 1'b1, 1'b1));
      do_tick(0, mk(4'hD, 4'h3, 7'h30, 1'b1, 1'b0));
      do_tick(0, mk(4'hB, 4'h2, 7'h24, 1'b1, 1'b0));
      do_tick(0, mk(4'h7, 4'h1, 7'h79, 1'b1, 1'b0));
      do_tick(0, mk(4'hE, 4'h4, 7'h19, 1'b1, 1'b1));
      do_tick(0, mk(4'hD, 4'h3, 7'h30, 1'b1, 1'b0));

      // Mid-frame value change is held off until the next wrap.
      q = 16'hABCD;
      do_tick(0, mk(4'hB, 4'h2, 7'h24, 1'b1, 1'b0));
      do_tick(0, mk(4'h7, 4'h1, 7'h79, 1'b1, 1'b0));
      do_tick(0, mk(4'hE, 4'hD, 7'h21, 1'b1, 1'b1));
      do_tick(0, mk(4'hD, 4'hC, 7'h46, 1'b1, 1'b0));
      do_tick(0, mk(4'hB, 4'hB, 7'h03, 1'b1, 1'b0));
      do_tick(0, mk(4'h7, 4'hA, 7'h08, 1'b1, 1'b0));

      // Display disable: takes effect one edge later, scanning continues.
      en = 1'b0;
      @(posedge clk); #1;
      chk_pins("en_off", pins0(), mk(4'hF, 4'hA, 7'h7F, 1'b1, 1'b0));
      @(negedge clk);
      dp = 4'b0100;
      do_tick(0, mk(4'hF, 4'hD, 7'h7F, 1'b1, 1'b1));
      do_tick(0, mk(4'hF, 4'hC, 7'h7F, 1'b1, 1'b0));
      do_tick(0, mk(4'hF, 4'hB, 7'h7F, 1'b1, 1'b0));
      do_tick(0, mk(4'hF, 4'hA, 7'h7F, 1'b1, 1'b0));
      en = 1'b1;
      @(posedge clk); #1;
      chk_pins("en_on", pins0(), mk(4'h7, 4'hA, 7'h08, 1'b1, 1'b0));
      @(negedge clk);
      do_tick(0, mk(4'hE, 4'hD, 7'h21, 1'b1, 1'b1));
      do_tick(0, mk(4'hD, 4'hC, 7'h46, 1'b1, 1'b0));
      do_tick(0, mk(4'hB, 4'hB, 7'h03, 1'b0, 1'b0));
      do_tick(0, mk(4'h7, 4'hA, 7'h08, 1'b1, 1'b0));

      // Reset mid-frame with a strobe rise pending: discarded.
      rst = 1'b1; clk_div0 = 1'b1;
      @(posedge clk); #1;
      chk_pins("midrst_u0", pins0(), mk(4'hF, 4'h0, 7'h7F, 1'b1, 1'b0));
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_pins("midrel_u0", pins0(), mk(4'hF, 4'h0, 7'h7F, 1'b1, 1'b0));
      clk_div0 = 1'b0;
      @(negedge clk);

      // ON=3 / BLANK=2 instance.
      q = 16'h1234; dp = 4'b0000;
      do_tick(1, mk(4'hF, 4'h0, 7'h7F, 1'b1, 1'b0));
      do_tick(1, mk(4'hE, 4'h4, 7'h19, 1'b1, 1'b1));
      do_tick(1, mk(4'hE, 4'h4, 7'h19, 1'b1, 1'b0));
      do_tick(1, mk(4'hE, 4'h4, 7'h19, 1'b1, 1'b0));
      do_tick(1, mk(4'hF, 4'h4, 7'h7F, 1'b1, 1'b0));
      do_tick(1, mk(4'hF, 4'h4, 7'h7F, 1'b1, 1'b0));
      do_tick(1, mk(4'hD, 4'h3, 7'h30, 1'b1, 1'b0));
      do_tick(1, mk(4'hD, 4'h3, 7'h30, 1'b1, 1'b0));
      do_tick(1, mk(4'hD, 4'h3, 7'h30, 1'b1, 1'b0));
      do_tick(1, mk(4'hF, 4'h3, 7'h7F, 1'b1, 1'b0));
      do_tick(1, mk(4'hF, 4'h3, 7'h7F, 1'b1, 1'b0));
      do_tick(1, mk(4'hB, 4'h2, 7'h24, 1'b1, 1'b0));

      // Leading zeros.
      q = 16'h0070;
      do_tick(0, mk(4'hE, 4'h0, 7'h40, 1'b1, 1'b1));
      do_tick(0, mk(4'hD, 4'h7, 7'h78, 1'b1, 1'b0));
`ifdef SEVSEG_LZB_EN
      do_tick(0, mk(4'hF, 4'h0, 7'h7F, 1'b1, 1'b0));
      do_tick(0, mk(4'hF, 4'h0, 7'h7F, 1'b1, 1'b0));
`else
      do_tick(0, mk(4'hB, 4'h0, 7'h40, 1'b1, 1'b0));
      do_tick(0, mk(4'h7, 4'h0, 7'h40, 1'b1, 1'b0));
`endif
      do_tick(0, mk(4'hE, 4'h0, 7'h40, 1'b1, 1'b1));

      repeat (4) @(negedge clk);
      chk("sb0_leftover", 32'(sb0.size()), 32'd0);
      chk("sb1_leftover", 32'(sb1.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
